// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch front end
//
// Drives a byte address into a combinational, little-endian instruction
// memory and captures each returned 32-bit word together with its PC in a
// small in-order queue. Decode drains the queue through a valid/ready
// handshake. A redirect from execute flushes the queue and restarts fetch.
// Fetch stops on a bad (misaligned or out-of-range) address. After the older
// good instructions have drained, fault is raised.
//
// Parameters:
//   RESET_PC   fetch address loaded on reset
//   QDEPTH     queue depth in entries (power of 2, >= 2)
//   MEM_BYTES  instruction memory size in bytes, used for range checking
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   imem_addr   out   byte address to the instruction memory (= fetch_pc)
//   imem_data   in    instruction word at imem_addr (combinational)
//   redirect    in    flush the queue and restart fetch at redirect_pc
//   redirect_pc in    new fetch address
//   out_valid   out   queue head holds an instruction
//   out_ready   in    decode accepts the head this cycle
//   out_ins     out   head instruction (0 when empty)
//   out_pc      out   head PC (0 when empty)
//   fault       out   fetch stopped on a bad address and the queue is empty
// ---------------------------------------------------------------------------
module ifetch #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned QDEPTH    = 2,
    parameter int unsigned MEM_BYTES = 80
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc,
    output logic        fault
);

    localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             bad_q, bad_d;
    logic [31:0]      pc_mem_q  [QDEPTH];
    logic [31:0]      pc_mem_d  [QDEPTH];
    logic [31:0]      ins_mem_q [QDEPTH];
    logic [31:0]      ins_mem_d [QDEPTH];

    logic             pop;
    logic             push;
    logic             bad_addr;
    logic [32:0]      last_byte;

    // Registered-only outputs: no path from out_ready to out_valid.
    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_ins   = out_valid ? ins_mem_q[head_q] : '0;
    assign out_pc    = out_valid ? pc_mem_q[head_q]  : '0;
    assign fault     = bad_q & (count_q == '0);

    always_comb begin
        pop       = out_valid & out_ready;
        // 33-bit sum so an address near 2^32 cannot wrap back into range.
        last_byte = {1'b0, fetch_pc_q} + 33'd3;
        bad_addr  = (fetch_pc_q[1:0] != 2'b00) || (last_byte >= 33'(MEM_BYTES));
        // A pop frees a slot in the same cycle, so a full queue still pushes.
        push      = !redirect && !bad_q && !bad_addr &&
                    ((count_q < CNT_W'(QDEPTH)) || pop);

        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        bad_d      = bad_q;
        pc_mem_d   = pc_mem_q;
        ins_mem_d  = ins_mem_q;

        if (redirect) begin
            // Flush everything, including an entry popped this cycle; that
            // pop has already been seen by decode as a completed transfer.
            fetch_pc_d = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            bad_d      = 1'b0;
        end else begin
            if (pop) begin
                head_d = head_q + 1'b1;
            end
            if (push) begin
                pc_mem_d[tail_q]  = fetch_pc_q;
                ins_mem_d[tail_q] = imem_data;
                tail_d            = tail_q + 1'b1;
                fetch_pc_d        = fetch_pc_q + 32'd4;
            end
            if (bad_addr) begin
                bad_d = 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            bad_q      <= 1'b0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            bad_q      <= bad_d;
            pc_mem_q   <= pc_mem_d;
            ins_mem_q  <= ins_mem_d;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch -- self-checking bench for ifetch.
// A transaction-level reference model (an SV queue of {pc, ins} plus a fetch
// address and a stop flag) predicts the outputs of every cycle. The driver
// pushes each prediction into a scoreboard queue. A separate monitor pops it
// on the falling edge and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_ifetch;

    localparam logic [31:0] RESET_PC  = 32'h0;
    localparam int unsigned QDEPTH    = 2;
    localparam int unsigned MEM_BYTES = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ifetch #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ins    (out_ins),
        .out_pc     (out_pc),
        .fault      (fault)
    );

    // Program image as words (the model's view) and as bytes (the memory).
    logic [31:0] img [4] = '{32'h00A00093, 32'h00400113, 32'h002080B3, 32'h0020A023};
    logic [7:0]  mem_bytes [MEM_BYTES];

    initial begin
        for (int w = 0; w < 4; w++) begin
            mem_bytes[4*w+0] = img[w][7:0];
            mem_bytes[4*w+1] = img[w][15:8];
            mem_bytes[4*w+2] = img[w][23:16];
            mem_bytes[4*w+3] = img[w][31:24];
        end
    end

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] w;
        w = 32'hBAD0_0000 | {16'h0, a[15:0]};
        if ({32'h0, a} + 64'd3 < 64'(MEM_BYTES))
            w = {mem_bytes[a+3], mem_bytes[a+2], mem_bytes[a+1], mem_bytes[a]};
        return w;
    endfunction

    assign imem_data = mem_read(imem_addr);

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } entry_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] addr;
        logic        fault;
    } exp_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    bit          m_stopped;
    exp_t        exp_q[$];

    task automatic model_reset();
        mq.delete();
        m_pc      = RESET_PC;
        m_stopped = 0;
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.valid = (mq.size() != 0);
        e.pc    = e.valid ? mq[0].pc  : 32'h0;
        e.ins   = e.valid ? mq[0].ins : 32'h0;
        e.addr  = m_pc;
        e.fault = m_stopped && (mq.size() == 0);
        return e;
    endfunction

    task automatic model_step(input bit r, input bit rd, input logic [31:0] rdpc, input bit rdy);
        bit     take;
        bit     bad;
        entry_t ne;
        take = (mq.size() != 0) && rdy;
        if (r) begin
            model_reset();
        end else if (rd) begin
            mq.delete();
            m_pc      = rdpc;
            m_stopped = 0;
        end else begin
            if (take) void'(mq.pop_front());
            bad = (m_pc % 4 != 0) || ({32'h0, m_pc} + 64'd3 >= 64'(MEM_BYTES));
            if (bad) begin
                m_stopped = 1;
            end else if (!m_stopped && mq.size() < QDEPTH) begin
                ne.pc  = m_pc;
                ne.ins = img[m_pc / 4];
                mq.push_back(ne);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit r, input bit rd, input logic [31:0] rdpc, input bit rdy);
        rst         = r;
        redirect    = rd;
        redirect_pc = rdpc;
        out_ready   = rdy;
        exp_q.push_back(model_outputs());
        model_step(r, rd, rdpc, rdy);
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_valid", {31'h0, out_valid}, {31'h0, e.valid});
            check("out_pc",    out_pc,    e.pc);
            check("out_ins",   out_ins,   e.ins);
            check("imem_addr", imem_addr, e.addr);
            check("fault",     {31'h0, fault}, {31'h0, e.fault});
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] targets [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h6, 32'h10,
                                 32'h2, 32'hFFFF_FFFC, 32'hFFFF_FFFD};

    initial begin
        logic [31:0] t;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // streaming
        cycle(1, 0, 0, 1);
        repeat (8) cycle(0, 0, 0, 1);

        // backpressure then release
        cycle(1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        repeat (8) cycle(0, 0, 0, 1);

        // redirect to 8 while head is PC 4
        cycle(1, 0, 0, 1);
        repeat (2) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h8, 1);
        repeat (4) cycle(0, 0, 0, 1);

        // range fault, then redirect to 0 clears it
        cycle(1, 0, 0, 1);
        repeat (8) cycle(0, 0, 0, 1);
        cycle(0, 1, 32'h0, 1);
        repeat (3) cycle(0, 0, 0, 1);

        // misaligned redirect
        cycle(0, 1, 32'h6, 1);
        repeat (3) cycle(0, 0, 0, 1);

        // reset with a full queue and redirect in the same cycle
        cycle(1, 0, 0, 0);
        repeat (4) cycle(0, 0, 0, 0);
        cycle(1, 1, 32'h8, 0);
        repeat (3) cycle(0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            t = ($urandom_range(0, 9) == 9) ? $urandom() : targets[$urandom_range(0, 8)];
            cycle($urandom_range(0, 63) == 0,
                  $urandom_range(0, 7) == 0,
                  t,
                  $urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch front end. Drives the byte address into the combinational, little-endian instruction memory and captures each 32-bit word with its PC in a small in-order queue. Presents the queue to decode with a valid/ready handshake. Supports a redirect (branch/jump) from execute that flushes all queued instructions.

## Interface
- RESET_PC, 32'h0, fetch address loaded on reset.
- QDEPTH, 2, queue depth in entries; power of 2, minimum 2.
- MEM_BYTES, 80, instruction memory size in bytes; used for range checking.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; one clock, synchronous, active-high.
- imem_addr  output  32  byte address to the instruction memory; equals fetch_pc.
- imem_data  input  32  instruction word from memory, combinational in imem_addr, byte at imem_addr in bits [7:0].
- redirect  input  1  flush and restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch address.
- out_valid  output  1  queue head holds an instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_ins  output  32  head instruction; 0 when the queue is empty.
- out_pc  output  32  head PC; 0 when the queue is empty.
- fault  output  1  fetch has stopped on a bad address and the queue has drained.

## Operation
- State:
  - fetch_pc, 32 bits.
  - Queue of QDEPTH {pc, ins} entries, with head/tail pointers and a count.
  - Sticky bad flag.
- pop = out_valid & out_ready.
- An address is bad if fetch_pc[1:0] != 0, or if fetch_pc + 3 >= MEM_BYTES. The comparison is unsigned and 33 bits wide, so fetch_pc near 2^32 does not wrap into range.
- push = !redirect & !bad_flag & !bad_addr & (count < QDEPTH | pop).
- On push: enqueue {fetch_pc, imem_data} at tail, and set fetch_pc <= fetch_pc + 4. The add is modulo 2^32.
- Bad address with no redirect: set bad_flag. No enqueue; fetch_pc holds.
- On redirect:
  - Clear the queue, including any entry popped in the same cycle. That pop still counts as a completed transfer to decode.
  - Set fetch_pc <= redirect_pc and clear bad_flag.
  - No enqueue this cycle.
- Redirect has priority over push and over setting bad_flag.
- fault = bad_flag & (count == 0). Older good instructions drain before fault asserts.
- out_valid = (count != 0). out_ins and out_pc come from the head entry.
- A full queue with a pop pushes in the same cycle, so throughput is 1 instruction per cycle.
- Memory contents are never written by this block.

## Timing
- Reset values:
  - fetch_pc = RESET_PC; imem_addr = RESET_PC.
  - count = 0; out_valid = 0; out_ins = 0; out_pc = 0.
  - bad_flag = 0; fault = 0.
- Reset mid-operation discards queue contents and any pending redirect. rst dominates redirect.
- First instruction latency: rst deasserted at edge E, so the word at RESET_PC enqueues at edge E+1 and out_valid = 1 in the cycle after E+1.
- Redirect latency: redirect in cycle N, then out_valid = 0 in N+1 and the target instruction is valid in N+2.
- With out_ready held low, the queue fills to QDEPTH. fetch_pc then stops at RESET_PC + 4*QDEPTH, and imem_addr stays stable.
- out_valid, out_ins and out_pc depend only on registered state. imem_addr depends only on fetch_pc. There is no combinational path from out_ready to out_valid.

## Test plan
Memory image: 0x00A00093 @0, 0x00400113 @4, 0x002080B3 @8, 0x0020A023 @12. Each word is stored as bytes, little-endian; e.g. 93 00 A0 00 at addresses 0..3.

- Streaming:
  - Stimulus: reset, out_ready = 1.
  - Required: out_pc/out_ins = 0/0x00A00093, 4/0x00400113, 8/0x002080B3, 12/0x0020A023 on consecutive cycles starting the second cycle after reset.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles, then 1.
  - Required: count saturates at 2 and imem_addr holds at 8. After release, PCs 0, 4, 8, 12 appear in order with no loss or duplicate.
- Redirect:
  - Stimulus: redirect = 1, redirect_pc = 8 while the head is PC 4 and out_ready = 1.
  - Required: PC 4 is consumed; out_valid = 0 the next cycle; then out_pc = 8, out_ins = 0x002080B3.
- Range fault:
  - Stimulus: run from reset with MEM_BYTES = 16.
  - Required: PCs 0..12 are delivered, then out_valid = 0 and fault = 1. A redirect to 0 clears fault, and 0x00A00093 reappears two cycles later.
- Misaligned:
  - Stimulus: redirect_pc = 6.
  - Required: nothing is enqueued and fault = 1 two cycles after the redirect.
- Reset mid-stream:
  - Stimulus: rst with a full queue and redirect asserted in the same cycle.
  - Required: out_valid = 0 the next cycle and imem_addr = RESET_PC.
